sync_fifo_flags: RTL

Parametrised next-generation synchronous FIFO: one clock domain, power-of-two depth, wrap-bit pointers, and added status outputs: fill count, programmable almost-full/almost-empty, and registered overflow/underflow pulses. It replaces the fixed controller/memory/pointer FIFO wherever a producer and consumer share `clk` and need early back-pressure. Optional first-word-fall-through (FWFT) read mode is selected at compile time.

---
 rtl/sync_fifo_pkg.sv | 28 ++
 rtl/sync_fifo_ptr.sv | 19 +
 rtl/sync_fifo_flags.sv | 107 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Types, depth/threshold helpers and the error-code enum used by the FIFO and its pointers.
package sync_fifo_pkg;

  localparam int unsigned W_ADDRESS_DEFAULT = 4;

  // Wrap-bit pointer for the default geometry; parametrised users pass their own width.
  typedef logic [W_ADDRESS_DEFAULT:0] ptr_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UNF
  } err_e;

  function automatic int unsigned fifo_depth(input int unsigned w_address);
    return 32'(1) << w_address;
  endfunction

  function automatic int unsigned default_af_thresh(input int unsigned w_address);
    return fifo_depth(w_address) - 32'd2;
  endfunction

  function automatic int unsigned default_ae_thresh(input int unsigned w_address);
    return (w_address > 0) ? 32'd2 : 32'd0;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrap-bit pointer counter: synchronous reset, increments modulo 2^width when enabled.
module sync_fifo_ptr #(
  parameter type ptr_t = sync_fifo_pkg::ptr_t
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output ptr_t ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ptr_t'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds and overflow/underflow pulses.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned W_DATA    = 8,
  parameter int unsigned W_ADDRESS = 4,
  parameter int unsigned AF_THRESH = default_af_thresh(W_ADDRESS),
  parameter int unsigned AE_THRESH = default_ae_thresh(W_ADDRESS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [W_DATA-1:0]    WRITE_DATA,
  output logic [W_DATA-1:0]    READ_DATA,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 ALMOST_FULL,
  output logic                 ALMOST_EMPTY,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW,
  output logic [W_ADDRESS:0]   COUNT
);

  localparam int unsigned DEPTH = fifo_depth(W_ADDRESS);

  typedef logic [W_ADDRESS:0] fifo_ptr_t;

  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_thresh_check
    $error("sync_fifo_flags: thresholds must satisfy AE_THRESH < AF_THRESH <= depth");
  end

  fifo_ptr_t   wptr;
  fifo_ptr_t   rptr;
  logic        wr_acc;
  logic        rd_acc;
  err_e        err;
  logic [W_DATA-1:0] mem [DEPTH];

  sync_fifo_ptr #(.ptr_t(fifo_ptr_t)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wptr)
  );

  sync_fifo_ptr #(.ptr_t(fifo_ptr_t)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rptr)
  );

  // Occupancy is pure pointer arithmetic; the wrap bit separates full from empty.
  assign EMPTY        = (wptr == rptr);
  assign FULL         = (wptr[W_ADDRESS] != rptr[W_ADDRESS]) &&
                        (wptr[W_ADDRESS-1:0] == rptr[W_ADDRESS-1:0]);
  assign COUNT        = wptr - rptr;
  assign ALMOST_FULL  = (32'(COUNT) >= AF_THRESH);
  assign ALMOST_EMPTY = (32'(COUNT) <= AE_THRESH);

  // Accept/reject decision; a reset cycle accepts nothing and flags nothing.
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    err    = ERR_NONE;
    if (!rst) begin
      wr_acc = wr && (!FULL || rd);
      rd_acc = rd && !EMPTY;
      if (wr && !wr_acc) begin
        err = ERR_OVF;
      end else if (rd && !rd_acc) begin
        err = ERR_UNF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= (err == ERR_OVF);
      UNDERFLOW <= (err == ERR_UNF);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[W_ADDRESS-1:0]] <= WRITE_DATA;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign READ_DATA = EMPTY ? '0 : mem[rptr[W_ADDRESS-1:0]];
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      READ_DATA <= '0;
    end else if (rd_acc) begin
      READ_DATA <= mem[rptr[W_ADDRESS-1:0]];
    end
  end
`endif

endmodule
